cacheline_adapter: RTL and testbench

Converts one cache's 256-bit line fill/writeback requests into the 64-bit, 4-beat burst protocol presented to `cache_arbiter`. It collects returning read beats back into a full line. One instance sits between each cache (I and D) and its request port on the arbiter. The D-side instance drives the arbiter's `write_complete`.

---
 rtl/cacheline_adapter.sv | 141 ++++++++++++++
 tb/tb_cacheline_adapter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adapter.sv
// Adapts 256-bit cache line fills/writebacks to the arbiter's 4 x 64-bit burst protocol
// and reassembles tagged read-return beats into a full line.
module cacheline_adapter (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  dfp_addr,
  input  logic         dfp_read,
  input  logic         dfp_write,
  input  logic [255:0] dfp_wdata,
  output logic [255:0] dfp_rdata,
  output logic         dfp_resp,
  output logic         arb_request,
  output logic [31:0]  arb_addr,
  output logic         arb_read,
  output logic         arb_write,
  output logic [63:0]  arb_wdata,
  input  logic         arb_ready,
  input  logic [31:0]  bmem_raddr,
  input  logic [63:0]  bmem_rdata,
  input  logic         bmem_rvalid,
  output logic         write_complete
);

  localparam int unsigned LINE_W = 256;
  localparam int unsigned BEAT_W = 64;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP} state_t;

  state_t              state_q;
  logic [1:0]          cnt_q;
  logic [ADDR_W-1:0]   line_q;
  logic [LINE_W-1:0]   wline_q;
  logic [LINE_W-1:0]   dfp_rdata_q;
  logic                dfp_resp_q;
  logic                arb_request_q;
  logic                arb_read_q;
  logic                arb_write_q;
  logic [ADDR_W-1:0]   arb_addr_q;
  logic [BEAT_W-1:0]   arb_wdata_q;

  logic [ADDR_W-1:0]   req_line;
  logic [1:0]          cnt_inc;
  logic                unused_addr_lsbs;

  assign req_line         = {dfp_addr[31:5], 5'b0};
  assign cnt_inc          = cnt_q + 2'd1;
  assign unused_addr_lsbs = ^dfp_addr[4:0];

  // Outputs are registered alongside the state they decode, so they track the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 2'd0;
      line_q        <= '0;
      wline_q       <= '0;
      dfp_rdata_q   <= '0;
      dfp_resp_q    <= 1'b0;
      arb_request_q <= 1'b0;
      arb_read_q    <= 1'b0;
      arb_write_q   <= 1'b0;
      arb_addr_q    <= '0;
      arb_wdata_q   <= '0;
    end else begin
      dfp_resp_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (dfp_write) begin
            state_q       <= WR_BURST;
            line_q        <= req_line;
            wline_q       <= dfp_wdata;
            cnt_q         <= 2'd0;
            arb_request_q <= 1'b1;
            arb_write_q   <= 1'b1;
            arb_addr_q    <= req_line;
            arb_wdata_q   <= dfp_wdata[BEAT_W-1:0];
          end else if (dfp_read) begin
            state_q       <= RD_REQ;
            line_q        <= req_line;
            arb_request_q <= 1'b1;
            arb_read_q    <= 1'b1;
            arb_addr_q    <= req_line;
          end
        end
        RD_REQ: begin
          if (arb_ready) begin
            state_q       <= RD_WAIT;
            cnt_q         <= 2'd0;
            arb_request_q <= 1'b0;
            arb_read_q    <= 1'b0;
            arb_addr_q    <= '0;
          end
        end
        RD_WAIT: begin
          // Beats tagged with another line belong to the other requester.
          if (bmem_rvalid && (bmem_raddr == line_q)) begin
            dfp_rdata_q[{cnt_q, 6'd0} +: BEAT_W] <= bmem_rdata;
            cnt_q <= cnt_inc;
            if (cnt_q == 2'd3) begin
              state_q    <= RESP;
              dfp_resp_q <= 1'b1;
            end
          end
        end
        WR_BURST: begin
          if (arb_ready) begin
            cnt_q <= cnt_inc;
            if (cnt_q == 2'd3) begin
              state_q       <= RESP;
              dfp_resp_q    <= 1'b1;
              arb_request_q <= 1'b0;
              arb_write_q   <= 1'b0;
              arb_addr_q    <= '0;
              arb_wdata_q   <= '0;
            end else begin
              arb_wdata_q <= wline_q[{cnt_inc, 6'd0} +: BEAT_W];
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Only combinational output: flags the cycle the last write beat is accepted.
  assign write_complete = (state_q == WR_BURST) && (cnt_q == 2'd3) && arb_ready && !rst;

  assign dfp_rdata   = dfp_rdata_q;
  assign dfp_resp    = dfp_resp_q;
  assign arb_request = arb_request_q;
  assign arb_addr    = arb_addr_q;
  assign arb_read    = arb_read_q;
  assign arb_write   = arb_write_q;
  assign arb_wdata   = arb_wdata_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Randomized self-checking bench for cacheline_adapter against a line/beat-level model.
module tb_cacheline_adapter;

  logic         clk;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic         arb_request;
  logic [31:0]  arb_addr;
  logic         arb_read;
  logic         arb_write;
  logic [63:0]  arb_wdata;
  logic         arb_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;
  logic         write_complete;

  int tests_run = 0;
  int fails = 0;

  cacheline_adapter dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .arb_request(arb_request), .arb_addr(arb_addr), .arb_read(arb_read),
    .arb_write(arb_write), .arb_wdata(arb_wdata), .arb_ready(arb_ready),
    .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid),
    .write_complete(write_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand64(), rand64(), rand64(), rand64()};
  endfunction

  // Full read transaction: request, optional grant stall, 4 matching beats with optional noise.
  task automatic do_read(input logic [31:0] addr, input int stall, input bit noise,
                         input bit use_fixed, input logic [255:0] fixed);
    logic [31:0]  line;
    logic [255:0] exp_line;
    logic [35:0]  got_rq, exp_rq;
    logic [3:0]   got_w, exp_w;
    logic [63:0]  beat;
    int k;
    line = {addr[31:5], 5'b0};
    exp_line = '0;
    dfp_addr = addr;
    dfp_read = 1'b1;
    arb_ready = 1'b0;
    step();
    dfp_read = 1'b0;
    exp_rq = {1'b1, 1'b1, 1'b0, line, 1'b0};
    for (int i = 0; i < stall; i++) begin
      got_rq = {arb_request, arb_read, arb_write, arb_addr, dfp_resp};
      tests_run++;
      if (got_rq !== exp_rq) begin
        fails++;
        $display("FAIL rd_req_hold cyc %0d: got %h exp %h", i, got_rq, exp_rq);
      end
      step();
    end
    got_rq = {arb_request, arb_read, arb_write, arb_addr, dfp_resp};
    tests_run++;
    if (got_rq !== exp_rq) begin
      fails++;
      $display("FAIL rd_req: got %h exp %h", got_rq, exp_rq);
    end
    arb_ready = 1'b1;
    step();
    arb_ready = $urandom_range(0, 1);
    k = 0;
    while (k < 4) begin
      got_w = {arb_request, arb_read, arb_write, dfp_resp};
      exp_w = 4'b0000;
      tests_run++;
      if (got_w !== exp_w) begin
        fails++;
        $display("FAIL rd_wait beat %0d: got %b exp %b", k, got_w, exp_w);
      end
      if (noise && ($urandom_range(0, 2) != 0)) begin
        if ($urandom_range(0, 1) != 0) begin
          bmem_raddr = line + 32'h20 * 32'($urandom_range(1, 200));
          bmem_rvalid = 1'b1;
        end else begin
          bmem_raddr = line;
          bmem_rvalid = 1'b0;
        end
        bmem_rdata = rand64();
      end else begin
        beat = use_fixed ? fixed[64*k +: 64] : rand64();
        exp_line[64*k +: 64] = beat;
        bmem_raddr = line;
        bmem_rdata = beat;
        bmem_rvalid = 1'b1;
        k++;
      end
      step();
    end
    bmem_rvalid = 1'b0;
    arb_ready = 1'b0;
    tests_run++;
    if (dfp_resp !== 1'b1) begin
      fails++;
      $display("FAIL rd_resp: got %b exp 1", dfp_resp);
    end
    tests_run++;
    if (dfp_rdata !== exp_line) begin
      fails++;
      $display("FAIL rd_data: got %h exp %h", dfp_rdata, exp_line);
    end
    step();
    tests_run++;
    if ({dfp_resp, dfp_rdata} !== {1'b0, exp_line}) begin
      fails++;
      $display("FAIL rd_after_resp: resp %b data %h exp 0/%h", dfp_resp, dfp_rdata, exp_line);
    end
  endtask

  // Full write transaction; ready pattern either given (LSB first) or random.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] wdata,
                          input bit use_pat, input logic [15:0] pat);
    logic [31:0]  line;
    logic [100:0] got_v, exp_v;
    logic         r;
    int k, cyc;
    line = {addr[31:5], 5'b0};
    dfp_addr = addr;
    dfp_wdata = wdata;
    dfp_write = 1'b1;
    step();
    dfp_write = 1'b0;
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 64) begin
      r = use_pat ? pat[cyc % 16] : 1'($urandom_range(0, 1));
      arb_ready = r;
      #1;
      got_v = {arb_request, arb_read, arb_write, arb_addr, arb_wdata, write_complete, dfp_resp};
      exp_v = {1'b1, 1'b0, 1'b1, line, wdata[64*k +: 64], (r && k == 3), 1'b0};
      tests_run++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL wr_beat k=%0d cyc=%0d: got %h exp %h", k, cyc, got_v, exp_v);
      end
      step();
      if (r) k++;
      cyc++;
    end
    arb_ready = 1'b1;
    #1;
    tests_run++;
    if ({dfp_resp, write_complete, arb_request, arb_write} !== 4'b1000) begin
      fails++;
      $display("FAIL wr_resp: got %b exp 1000",
               {dfp_resp, write_complete, arb_request, arb_write});
    end
    arb_ready = 1'b0;
    step();
    tests_run++;
    if ({dfp_resp, write_complete} !== 2'b00) begin
      fails++;
      $display("FAIL wr_after_resp: got %b exp 00", {dfp_resp, write_complete});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    arb_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    tests_run++;
    if ({dfp_resp, arb_request, arb_read, arb_write, write_complete, arb_addr, arb_wdata} !== '0) begin
      fails++;
      $display("FAIL reset_ctrl: got %h exp 0",
               {dfp_resp, arb_request, arb_read, arb_write, write_complete, arb_addr, arb_wdata});
    end
    tests_run++;
    if (dfp_rdata !== '0) begin
      fails++;
      $display("FAIL reset_rdata: got %h exp 0", dfp_rdata);
    end
  endtask

  task automatic test_read_basic();
    logic [255:0] f;
    f = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_read(32'h0000_1234, 0, 1'b0, 1'b1, f);
  endtask

  task automatic test_write_basic();
    logic [255:0] w;
    w = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    do_write(32'h0000_5678, w, 1'b1, 16'b1111_1111_1111_1101);
  endtask

  task automatic test_foreign_beats();
    for (int i = 0; i < 3; i++)
      do_read($urandom, $urandom_range(0, 3), 1'b1, 1'b0, '0);
  endtask

  task automatic test_grant_stall();
    do_read(32'h8000_0040, 10, 1'b0, 1'b0, '0);
  endtask

  task automatic test_simultaneous();
    logic [255:0] w;
    w = rand256();
    dfp_read = 1'b1;
    do_write(32'h0000_2000, w, 1'b1, 16'hFFFF);
    #1;
    tests_run++;
    if ({arb_request, arb_read, dfp_resp} !== 3'b000) begin
      fails++;
      $display("FAIL simul_idle: got %b exp 000", {arb_request, arb_read, dfp_resp});
    end
    do_read(32'h0000_2000, 1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset_mid_burst();
    dfp_addr = 32'h0000_3000;
    dfp_wdata = rand256();
    dfp_write = 1'b1;
    step();
    dfp_write = 1'b0;
    arb_ready = 1'b1;
    step();
    step();
    rst = 1'b1;
    #1;
    tests_run++;
    if (write_complete !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_wc: got %b exp 0", write_complete);
    end
    step();
    rst = 1'b0;
    #1;
    tests_run++;
    if ({dfp_resp, arb_request, arb_read, arb_write, write_complete, arb_addr, arb_wdata, dfp_rdata} !== '0) begin
      fails++;
      $display("FAIL rst_mid_wr: got %h exp 0",
               {dfp_resp, arb_request, arb_read, arb_write, write_complete, arb_addr, arb_wdata});
    end
    arb_ready = 1'b0;
    dfp_addr = 32'h0000_4000;
    dfp_read = 1'b1;
    step();
    dfp_read = 1'b0;
    arb_ready = 1'b1;
    step();
    arb_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bmem_raddr = 32'h0000_4000;
      bmem_rdata = rand64();
      bmem_rvalid = 1'b1;
      step();
    end
    bmem_rvalid = 1'b0;
    tests_run++;
    if ({dfp_resp, arb_request, dfp_rdata} !== '0) begin
      fails++;
      $display("FAIL rst_mid_rd: resp %b req %b data %h exp 0", dfp_resp, arb_request, dfp_rdata);
    end
  endtask

  task automatic test_random_mix();
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) != 0)
        do_write($urandom, rand256(), 1'b0, '0);
      else
        do_read($urandom, $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b0, '0);
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_basic();
    test_foreign_beats();
    test_grant_stall();
    test_simultaneous();
    test_reset_mid_burst();
    test_random_mix();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
